// File: rtl/piso_tx_311_pkg.sv
// Shared types and constants for the piso_tx_311 serial transmitter.
package piso_tx_311_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Level the serial line rests at between frames (also the stop-bit level)
    localparam logic LINE_IDLE = 1'b1;

    // Bits needed to count 0..width inclusive, i.e. ceil(log2(width+1)), minimum 1
    function automatic int cnt_width(input int width);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (width + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/shreg_311.sv
// Parallel-load, right-shift payload register; bit 0 is the next bit on the line.
module shreg_311 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] q_reg;

    // Load has priority over shift; shifting moves the next payload bit into bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= din;
        end else if (shift) begin
            q_reg <= q_reg >> 1;
        end
    end

    assign lsb = q_reg[0];

endmodule

// File: rtl/piso_tx_311.sv
// Parallel-in serial-out framer: start bit, LSB-first payload, optional even parity, stop bit.
module piso_tx_311
    import piso_tx_311_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset_311,
    input  logic             load_311,
    input  logic [WIDTH-1:0] data_311,
    output logic             sout_311,
    output logic             soutb_311,
    output logic             busy_311,
    output logic             done_311
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t        state_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic          parity_reg;
    logic          sout_reg;
    logic          busy_reg;
    logic          done_reg;

    logic          accept;
    logic          shift_en;
    logic          shreg_lsb;

    // A load is only honoured while idle, so anything arriving mid-frame is dropped
    assign accept   = (state_reg == IDLE) && load_311;
    // Advance the payload each time a bit is moved onto the line (START and all but the last DATA cycle)
    assign shift_en = (state_reg == START) ||
                      ((state_reg == DATA) && (bit_cnt_reg != CNT_LAST));

    shreg_311 #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (reset_311),
        .load  (accept),
        .shift (shift_en),
        .din   (data_311),
        .lsb   (shreg_lsb)
    );

    // Frame sequencer; every output is registered one state ahead so it lines up with the state it belongs to
    always_ff @(posedge clk or posedge reset_311) begin
        if (reset_311) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            sout_reg    <= LINE_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    sout_reg <= LINE_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (load_311) begin
                        state_reg   <= START;
                        bit_cnt_reg <= '0;
                        // Parity is taken from the captured word, so later data_311 changes cannot affect it
                        parity_reg  <= ^data_311;
                        sout_reg    <= ~LINE_IDLE;
                        busy_reg    <= 1'b1;
                    end
                end
                START: begin
                    state_reg   <= DATA;
                    sout_reg    <= shreg_lsb;
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                end
                DATA: begin
                    // bit_cnt_reg holds the number of payload bits already driven; it stops at WIDTH
                    if (bit_cnt_reg == CNT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_reg <= PARITY;
                            sout_reg  <= parity_reg;
                        end else begin
                            state_reg <= STOP;
                            sout_reg  <= LINE_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        sout_reg    <= shreg_lsb;
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                PARITY: begin
                    state_reg <= STOP;
                    sout_reg  <= LINE_IDLE;
                    done_reg  <= 1'b1;
                end
                STOP: begin
                    state_reg <= IDLE;
                    sout_reg  <= LINE_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    sout_reg  <= LINE_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sout_311  = sout_reg;
    // Derived from the same register so the pair stays complementary even while reset is held
    assign soutb_311 = ~sout_reg;
    assign busy_311  = busy_reg;
    assign done_311  = done_reg;

endmodule

// File: tb/tb_piso_tx_311.sv
// Directed self-checking bench for piso_tx_311 (parity and no-parity instances share stimulus).
module tb_piso_tx_311;

    logic       clk = 1'b0;
    logic       reset_311;
    logic       load_311;
    logic [7:0] data_311;

    logic sout, soutb, busy, done;
    logic sout_np, soutb_np, busy_np, done_np;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_tx_311 #(.WIDTH(8), .PARITY_EN(1)) dut (
        .clk       (clk),
        .reset_311 (reset_311),
        .load_311  (load_311),
        .data_311  (data_311),
        .sout_311  (sout),
        .soutb_311 (soutb),
        .busy_311  (busy),
        .done_311  (done)
    );

    piso_tx_311 #(.WIDTH(8), .PARITY_EN(0)) dut_np (
        .clk       (clk),
        .reset_311 (reset_311),
        .load_311  (load_311),
        .data_311  (data_311),
        .sout_311  (sout_np),
        .soutb_311 (soutb_np),
        .busy_311  (busy_np),
        .done_311  (done_np)
    );

    task automatic idle_gap(input int n);
        load_311 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_311 = 1'b1;
        load_311  = 1'b0;
        data_311  = 8'h00;
        #3;
        n_checks++;
        if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", sout, soutb, busy, done);
        end
        n_checks++;
        if (sout_np !== 1'b1 || soutb_np !== 1'b0 || busy_np !== 1'b0 || done_np !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_np: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", sout_np, soutb_np, busy_np, done_np);
        end
        #5;
        reset_311 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", sout, soutb, busy, done);
        end
        $display("test_reset: done");
    endtask

    task automatic test_frame_a5();
        logic [0:10] exp;
        exp = 11'b01010010101;
        @(negedge clk);
        load_311 = 1'b1;
        data_311 = 8'hA5;
        @(negedge clk);
        load_311 = 1'b0;
        data_311 = 8'h00;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (sout !== exp[i] || soutb !== ~exp[i] || busy !== 1'b1 || done !== (i == 10)) begin
                n_fail++;
                $display("FAIL frame_a5 cycle %0d: sout=%b soutb=%b busy=%b done=%b, expected sout=%b soutb=%b busy=1 done=%b",
                         i, sout, soutb, busy, done, exp[i], ~exp[i], (i == 10));
            end
            @(negedge clk);
        end
        n_checks++;
        if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_a5_idle: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", sout, soutb, busy, done);
        end
        $display("test_frame_a5: data=a5 frame sent");
    endtask

    task automatic test_parity_07();
        logic [0:10] exp;
        exp = 11'b01110000011;
        @(negedge clk);
        load_311 = 1'b1;
        data_311 = 8'h07;
        @(negedge clk);
        load_311 = 1'b0;
        data_311 = 8'hFF;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (sout !== exp[i] || soutb !== ~exp[i] || busy !== 1'b1 || done !== (i == 10)) begin
                n_fail++;
                $display("FAIL parity_07 cycle %0d: sout=%b soutb=%b busy=%b done=%b, expected sout=%b busy=1 done=%b",
                         i, sout, soutb, busy, done, exp[i], (i == 10));
            end
            n_checks++;
            if (sout_np !== exp[i] || soutb_np !== ~exp[i] || busy_np !== (i < 10) || done_np !== (i == 9)) begin
                n_fail++;
                $display("FAIL noparity_07 cycle %0d: sout=%b soutb=%b busy=%b done=%b, expected sout=%b busy=%b done=%b",
                         i, sout_np, soutb_np, busy_np, done_np, exp[i], (i < 10), (i == 9));
            end
            @(negedge clk);
        end
        $display("test_parity_07: parity and no-parity frames sent");
    endtask

    task automatic test_ignore_3c();
        logic [0:10] exp;
        exp = 11'b00011110001;
        @(negedge clk);
        load_311 = 1'b1;
        data_311 = 8'h3C;
        @(negedge clk);
        load_311 = 1'b0;
        data_311 = 8'h00;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (sout !== exp[i] || soutb !== ~exp[i] || busy !== 1'b1 || done !== (i == 10)) begin
                n_fail++;
                $display("FAIL ignore_3c cycle %0d: sout=%b soutb=%b busy=%b done=%b, expected sout=%b busy=1 done=%b",
                         i, sout, soutb, busy, done, exp[i], (i == 10));
            end
            load_311 = (i == 4) || (i == 10);
            data_311 = load_311 ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        load_311 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_3c_idle %0d: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", i, sout, soutb, busy, done);
            end
            @(negedge clk);
        end
        $display("test_ignore_3c: busy loads dropped");
    endtask

    task automatic test_back_to_back();
        logic [0:23] exp;
        logic        exp_busy;
        logic        exp_done;
        exp = 24'b010000001011001000010011;
        @(negedge clk);
        load_311 = 1'b1;
        data_311 = 8'h81;
        @(negedge clk);
        load_311 = 1'b0;
        data_311 = 8'h00;
        for (int i = 0; i < 24; i++) begin
            exp_busy = !((i == 11) || (i == 23));
            exp_done = (i == 10) || (i == 22);
            n_checks++;
            if (sout !== exp[i] || soutb !== ~exp[i] || busy !== exp_busy || done !== exp_done) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: sout=%b soutb=%b busy=%b done=%b, expected sout=%b busy=%b done=%b",
                         i, sout, soutb, busy, done, exp[i], exp_busy, exp_done);
            end
            load_311 = (i == 11);
            data_311 = (i == 11) ? 8'h42 : 8'h00;
            @(negedge clk);
        end
        load_311 = 1'b0;
        $display("test_back_to_back: frames 81 and 42 sent");
    endtask

    task automatic test_reset_mid();
        logic [0:5] exp;
        exp = 6'b000001;
        @(negedge clk);
        load_311 = 1'b1;
        data_311 = 8'hF0;
        @(negedge clk);
        load_311 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (sout !== exp[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: sout=%b busy=%b, expected sout=%b busy=1", i, sout, busy, exp[i]);
            end
            if (i < 5) @(negedge clk);
        end
        #2;
        reset_311 = 1'b1;
        #1;
        n_checks++;
        if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", sout, soutb, busy, done);
        end
        @(negedge clk);
        #2;
        reset_311 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (sout !== 1'b1 || soutb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_residual %0d: sout=%b soutb=%b busy=%b done=%b, expected 1 0 0 0", i, sout, soutb, busy, done);
            end
            @(negedge clk);
        end
        load_311 = 1'b1;
        data_311 = 8'h55;
        @(negedge clk);
        load_311 = 1'b0;
        n_checks++;
        if (sout !== 1'b0 || soutb !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reload_start: sout=%b soutb=%b busy=%b, expected 0 1 1", sout, soutb, busy);
        end
        @(negedge clk);
        n_checks++;
        if (sout !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reload_bit0: sout=%b busy=%b, expected 1 1", sout, busy);
        end
        @(negedge clk);
        n_checks++;
        if (sout !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reload_bit1: sout=%b busy=%b, expected 0 1", sout, busy);
        end
        $display("test_reset_mid: frame aborted and restarted");
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        idle_gap(14);
        test_parity_07();
        idle_gap(14);
        test_ignore_3c();
        idle_gap(14);
        test_back_to_back();
        idle_gap(14);
        test_reset_mid();
        idle_gap(14);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
